// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch port: request/address out, ack/data back.
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, imem req/ack fetch, IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    input  logic                 stall,
    input  logic                 flush,
    fetch_stage_if.master        imem,
    output logic [31:0]          pc,
    output logic                 ifid_valid,
    output logic [31:0]          ifid_pc,
    output logic [31:0]          ifid_instr
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        kill;
    logic [31:0] kill_pc;
    logic [31:0] hold_buf;
    logic [31:0] pc_next;
    logic [31:0] target;
    logic        ack_req;
    logic        take_word;
    logic        redir_take;
    logic        kill_drop;
    logic        accept_req;
    logic        accept_hold;
    logic        accept;
    logic [31:0] load_word;

    assign target      = {redirect_pc[31:2], 2'b00};
    assign ack_req     = (state == S_REQ) && imem.ack;
    assign take_word   = ack_req && !kill && !redirect_valid;
    assign redir_take  = redirect_valid && (ack_req || state == S_HOLD);
    assign kill_drop   = ack_req && kill && !redirect_valid;
    assign accept_req  = take_word && !stall;
    assign accept_hold = (state == S_HOLD) && !redirect_valid && !stall;
    assign accept      = accept_req || accept_hold;
    assign load_word   = accept_req ? imem.rdata : hold_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_REQ: begin
                if (take_word && stall) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid || !stall) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    // Request is masked during reset even though the state already reads S_REQ.
    always_comb begin
        imem.req  = (state == S_REQ) && !rst;
        imem.addr = pc;
    end

    always_comb begin
        pc_next = pc;
        unique case (1'b1)
            redir_take: pc_next = target;
            kill_drop:  pc_next = kill_pc;
            accept:     pc_next = pc + 32'd4;
            default:    pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            kill     <= 1'b0;
            kill_pc  <= 32'd0;
            hold_buf <= 32'd0;
        end else begin
            pc <= pc_next;
            if (ack_req) begin
                kill <= 1'b0;
            end else if (state == S_REQ && redirect_valid) begin
                kill    <= 1'b1;
                kill_pc <= target;
            end
            if (take_word && stall) begin
                hold_buf <= imem.rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= 32'd0;
            ifid_instr <= 32'd0;
        end else if (flush || redirect_valid) begin
            ifid_valid <= 1'b0;
        end else if (stall) begin
            ifid_valid <= ifid_valid;
        end else if (accept) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= pc;
            ifid_instr <= load_word;
        end else begin
            ifid_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus latency, wrap and reset sequences.
module tb_fetch_stage;

    localparam logic [31:0] K = 32'hA5A5_A5A5;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        stall;
        logic        flush;
        logic        ack;
        logic        req;
        logic [31:0] pc;
        logic        v;
        logic        chk;
        logic [31:0] ipc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        flush;
    logic [31:0] pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;

    int total = 0;
    int pass  = 0;

    vec_t tbl [23];

    fetch_stage_if imem ();

    assign imem.rdata = imem.addr ^ K;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .flush          (flush),
        .imem           (imem),
        .pc             (pc),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_instr     (ifid_instr)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        logic r, logic rv, logic [31:0] rpc, logic st, logic fl, logic ak,
        logic rq, logic [31:0] p, logic v, logic ck, logic [31:0] ip
    );
        vec_t t;
        t.rst = r;   t.rv = rv;   t.rpc = rpc;
        t.stall = st; t.flush = fl; t.ack = ak;
        t.req = rq;  t.pc = p;    t.v = v;
        t.chk = ck;  t.ipc = ip;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) begin
            pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic rv, logic [31:0] rpc, logic st, logic fl, logic ak);
        redirect_valid = rv;
        redirect_pc    = rpc;
        stall          = st;
        flush          = fl;
        imem.ack       = ak;
    endtask

    initial begin
        drive(0, 0, 0, 0, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_req",   {31'd0, imem.req}, 32'd0);
        chk("rst_pc",    pc, 32'h3000);
        chk("rst_addr",  imem.addr, 32'h3000);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_ipc",   ifid_pc, 32'd0);
        chk("rst_instr", ifid_instr, 32'd0);

        tbl[0]  = mk(1, 0, 0,           0, 0, 1,  0, 32'h3000, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0,           0, 0, 1,  1, 32'h3004, 1, 1, 32'h3000);
        tbl[2]  = mk(0, 0, 0,           0, 0, 1,  1, 32'h3008, 1, 1, 32'h3004);
        tbl[3]  = mk(0, 0, 0,           1, 0, 1,  0, 32'h3008, 1, 1, 32'h3004);
        tbl[4]  = mk(0, 0, 0,           1, 0, 1,  0, 32'h3008, 1, 1, 32'h3004);
        tbl[5]  = mk(0, 0, 0,           0, 0, 0,  1, 32'h300C, 1, 1, 32'h3008);
        tbl[6]  = mk(0, 0, 0,           0, 0, 1,  1, 32'h3010, 1, 1, 32'h300C);
        tbl[7]  = mk(0, 1, 32'h3203,    0, 0, 1,  1, 32'h3200, 0, 1, 32'h300C);
        tbl[8]  = mk(0, 0, 0,           0, 0, 1,  1, 32'h3204, 1, 1, 32'h3200);
        tbl[9]  = mk(0, 0, 0,           1, 1, 0,  1, 32'h3204, 0, 1, 32'h3200);
        tbl[10] = mk(0, 0, 0,           0, 1, 1,  1, 32'h3208, 0, 1, 32'h3200);
        tbl[11] = mk(0, 0, 0,           0, 0, 1,  1, 32'h320C, 1, 1, 32'h3208);
        tbl[12] = mk(0, 0, 0,           1, 0, 1,  0, 32'h320C, 1, 1, 32'h3208);
        tbl[13] = mk(0, 1, 32'h3400,    1, 0, 0,  1, 32'h3400, 0, 1, 32'h3208);
        tbl[14] = mk(0, 0, 0,           0, 0, 1,  1, 32'h3404, 1, 1, 32'h3400);
        tbl[15] = mk(0, 0, 0,           0, 0, 0,  1, 32'h3404, 0, 1, 32'h3400);
        tbl[16] = mk(0, 1, 32'h3100,    0, 0, 0,  1, 32'h3404, 0, 1, 32'h3400);
        tbl[17] = mk(0, 0, 0,           0, 0, 1,  1, 32'h3100, 0, 1, 32'h3400);
        tbl[18] = mk(0, 0, 0,           0, 0, 1,  1, 32'h3104, 1, 1, 32'h3100);
        tbl[19] = mk(0, 1, 32'h3500,    0, 0, 0,  1, 32'h3104, 0, 1, 32'h3100);
        tbl[20] = mk(0, 1, 32'h3600,    0, 0, 0,  1, 32'h3104, 0, 1, 32'h3100);
        tbl[21] = mk(0, 1, 32'h3700,    0, 0, 1,  1, 32'h3700, 0, 1, 32'h3100);
        tbl[22] = mk(0, 0, 0,           0, 0, 1,  1, 32'h3704, 1, 1, 32'h3700);

        for (int i = 0; i < 23; i++) begin
            rst = tbl[i].rst;
            drive(tbl[i].rv, tbl[i].rpc, tbl[i].stall, tbl[i].flush, tbl[i].ack);
            step();
            chk($sformatf("v%0d_req", i), {31'd0, imem.req}, {31'd0, tbl[i].req});
            chk($sformatf("v%0d_pc", i), pc, tbl[i].pc);
            chk($sformatf("v%0d_addr", i), imem.addr, tbl[i].pc);
            chk($sformatf("v%0d_valid", i), {31'd0, ifid_valid}, {31'd0, tbl[i].v});
            if (tbl[i].chk) begin
                chk($sformatf("v%0d_ipc", i), ifid_pc, tbl[i].ipc);
                chk($sformatf("v%0d_instr", i), ifid_instr, tbl[i].ipc ^ K);
            end
        end

        // Three wait cycles per fetch: one IF/ID pulse every fourth edge.
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 3; c++) begin
                imem.ack = 1'b0;
                step();
                chk($sformatf("lat%0d_%0d_addr", i, c), imem.addr, 32'h3000 + 32'(4 * i));
                chk($sformatf("lat%0d_%0d_req", i, c), {31'd0, imem.req}, 32'd1);
                chk($sformatf("lat%0d_%0d_valid", i, c), {31'd0, ifid_valid}, 32'd0);
            end
            imem.ack = 1'b1;
            step();
            chk($sformatf("lat%0d_valid", i), {31'd0, ifid_valid}, 32'd1);
            chk($sformatf("lat%0d_ipc", i), ifid_pc, 32'h3000 + 32'(4 * i));
            chk($sformatf("lat%0d_next", i), imem.addr, 32'h3004 + 32'(4 * i));
        end

        drive(1, 32'hFFFF_FFFC, 0, 0, 1);
        step();
        chk("wrap_pc0", pc, 32'hFFFF_FFFC);
        chk("wrap_valid0", {31'd0, ifid_valid}, 32'd0);
        drive(0, 0, 0, 0, 1);
        step();
        chk("wrap_pc1", pc, 32'd0);
        chk("wrap_ipc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", ifid_instr, 32'h5A5A_5A59);
        chk("wrap_valid1", {31'd0, ifid_valid}, 32'd1);

        // Reset lands mid-cycle with a killed fetch still outstanding.
        drive(1, 32'h3300, 0, 0, 0);
        step();
        chk("kill_pc_hold", pc, 32'd0);
        drive(0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", {31'd0, imem.req}, 32'd0);
        chk("arst_pc", pc, 32'h3000);
        chk("arst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("arst_ipc", ifid_pc, 32'd0);
        chk("arst_instr", ifid_instr, 32'd0);
        step();
        rst = 1'b0;
        imem.ack = 1'b1;
        step();
        chk("post_pc", pc, 32'h3004);
        chk("post_valid", {31'd0, ifid_valid}, 32'd1);
        chk("post_ipc", ifid_pc, 32'h3000);
        chk("post_instr", ifid_instr, 32'h3000 ^ K);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
